multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- FSM control unit that sequences a multicycle version of the ARM-subset datapath.
- One instruction runs over 3–5 states; a single shared memory port serves both fetch and data.
- Contains the condition unit and the NZCV flags register.
- Drives every datapath select and enable; accepts a memory-ready handshake so the core can run against slow memory.

Parameters:
- None. The ISA subset is fixed.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- Instr  in  20  Instr[31:12] from the instruction register: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- MemReady  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  memory write strobe
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- ALUSrcA  out  1  ALU A select: 0 = RD1, 1 = PC
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = ReadData, 10 = ALUResult
- ImmSrc  out  2  extend mode: 00 = DP imm8, 01 = mem imm12, 10 = branch imm24
- RegSrc  out  2  register address selects, same meaning as in the single-cycle datapath
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- Flags  out  4  registered NZCV
- State  out  4  current state encoding, for debug

Behaviour:
- Reset (async, reset=0):
  - state = FETCH, Flags = 0000.
  - PCWrite, IRWrite, RegWrite and MemWrite forced to 0 while reset is low.
  - Reset during any wait state aborts the access immediately; MemWrite drops combinationally.
- Output timing: all outputs are Moore functions of state. Exceptions:
  - IRWrite/PCWrite in FETCH are qualified by MemReady.
  - ALUControl, ImmSrc and RegSrc are decoded combinationally from Instr.
  - Any output not listed for a state is 0.
- Static decode:
  - ImmSrc = Op.
  - RegSrc[0] = (Op==10).
  - RegSrc[1] = (Op==01 & Funct[0]==0) (STR).
- ALU decode, in EXECUTE states only, from cmd = Funct[4:1]:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - 1010 CMP: SUB with no writeback; S is treated as 1.
  - Any other cmd is a NOP: no register or flag write.
  - All other states use ADD.
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=PCWrite=MemReady. Stays until MemReady=1, then goes to DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (forms PC+8). If the condition fails, go to FETCH. Otherwise branch on Op:
    - 01 → MEMADR
    - 00 with Funct[5]=0 → EXECUTER
    - 00 with Funct[5]=1 → EXECUTEI
    - 10 → BRANCH
    - 11 → FETCH (undefined instruction, ignored)
  - MEMADR: ALUSrcB=01. Next is MEMREAD if Funct[0]=1, else MEMWRITE.
  - MEMREAD: AdrSrc=1. Stays until MemReady=1, then goes to MEMWB.
  - MEMWB: ResultSrc=01, writeback (see below). Next is FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1, held until MemReady=1. Next is FETCH.
  - EXECUTER: ALUSrcB=00. Next is ALUWB.
  - EXECUTEI: ALUSrcB=01. Next is ALUWB.
  - ALUWB: ResultSrc=00, writeback unless the instruction is CMP or NOP. Next is FETCH.
  - BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite=1. Next is FETCH. The link bit is ignored.
- Writeback rule: if Rd==1111, assert PCWrite (not RegWrite); otherwise assert RegWrite.
- Condition (from registered Flags):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 → 0.
- Flags update, on the clock edge leaving EXECUTER/EXECUTEI, only when S=1 (or CMP):
  - N and Z are loaded from ALUFlags.
  - C and V are loaded only for ADD, SUB and CMP; they hold for AND and ORR.
- Latency with MemReady tied to 1:
  - DP: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Condition-failed: 2 cycles.

Test Plan:
- Reset low mid-MEMWRITE with MemReady=0 → MemWrite=0 immediately; State=FETCH, Flags=0000 after release; first FETCH raises IRWrite only once MemReady=1.
- ADD R1,R2,#5 (0xE2821005), MemReady=1 → FETCH,DECODE,EXECUTEI,ALUWB; ALUSrcB=01 in EXECUTEI; RegWrite=1 only in ALUWB; ALUControl=000.
- LDR R0,[R1,#4] (0xE5910004), MemReady low 3 cycles in MEMREAD → stays in MEMREAD 4 cycles with AdrSrc=1; MEMWB has ResultSrc=01, RegWrite=1.
- CMP R0,R0 (0xE1500000) with ALUFlags=0110 → RegWrite never 1; Flags=0110 after EXECUTER.
- BEQ (0x0A000002): with Z=1 → BRANCH, PCWrite=1, ImmSrc=10, RegSrc[0]=1. With Z=0 → DECODE→FETCH, no PCWrite outside FETCH.
- STR R3,[R4] (0xE5843000), MemReady=1 → MEMWRITE for 1 cycle with MemWrite=1, RegSrc=10; MOV-to-PC-style ADD PC,R0,#0 (0xE280F000) → ALUWB asserts PCWrite, not RegWrite.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control unit.
// Sequences fetch/decode/execute over a shared memory port; holds NZCV.
module multicycle_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  input  logic         MemReady,
  output logic         PCWrite,
  output logic         IRWrite,
  output logic         RegWrite,
  output logic         MemWrite,
  output logic         AdrSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic [2:0]   ALUControl,
  output logic [3:0]   Flags,
  output logic [3:0]   State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next;
  logic [3:0] r_flags;

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic [3:0] w_cmd;
  logic       w_s;
  logic       w_unused_rn;

  assign w_cond  = Instr[31:28];
  assign w_op    = Instr[27:26];
  assign w_funct = Instr[25:20];
  assign w_rd    = Instr[15:12];
  assign w_cmd   = w_funct[4:1];
  assign w_s     = w_funct[0];
  assign w_unused_rn = ^Instr[19:16];

  logic w_is_add;
  logic w_is_sub;
  logic w_is_and;
  logic w_is_orr;
  logic w_is_cmp;
  logic w_alu_wb;
  logic w_exec;
  logic w_flag_we;
  logic w_cv_we;

  assign w_is_add = (w_cmd == 4'b0100);
  assign w_is_sub = (w_cmd == 4'b0010);
  assign w_is_and = (w_cmd == 4'b0000);
  assign w_is_orr = (w_cmd == 4'b1100);
  assign w_is_cmp = (w_cmd == 4'b1010);

  // CMP and undefined cmds never write a register
  assign w_alu_wb = w_is_add | w_is_sub
                  | w_is_and | w_is_orr;

  assign w_exec = (r_state == EXECUTER)
                | (r_state == EXECUTEI);

  assign w_flag_we = w_exec
                   & ((w_s & w_alu_wb) | w_is_cmp);

  // logical ops leave carry and overflow alone
  assign w_cv_we = w_is_add | w_is_sub | w_is_cmp;

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_cond_ok;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // condition unit, evaluated against registered flags
  always_comb begin
    w_cond_ok = 1'b0;
    unique case (w_cond)
      4'b0000: w_cond_ok = w_z;
      4'b0001: w_cond_ok = ~w_z;
      4'b0010: w_cond_ok = w_c;
      4'b0011: w_cond_ok = ~w_c;
      4'b0100: w_cond_ok = w_n;
      4'b0101: w_cond_ok = ~w_n;
      4'b0110: w_cond_ok = w_v;
      4'b0111: w_cond_ok = ~w_v;
      4'b1000: w_cond_ok = w_c & ~w_z;
      4'b1001: w_cond_ok = ~w_c | w_z;
      4'b1010: w_cond_ok = (w_n == w_v);
      4'b1011: w_cond_ok = (w_n != w_v);
      4'b1100: w_cond_ok = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ok = w_z | (w_n != w_v);
      4'b1110: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // NZCV register, loaded as the execute state is left
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if (w_flag_we) begin
      r_flags[3:2] <= ALUFlags[3:2];
      if (w_cv_we) begin
        r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FETCH: begin
        if (MemReady) w_next = DECODE;
      end
      DECODE: begin
        if (!w_cond_ok) begin
          w_next = FETCH;
        end else begin
          unique case (w_op)
            2'b01: w_next = MEMADR;
            2'b00: w_next = w_funct[5] ? EXECUTEI
                                       : EXECUTER;
            2'b10: w_next = BRANCH;
            default: w_next = FETCH;
          endcase
        end
      end
      MEMADR: begin
        w_next = w_funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        if (MemReady) w_next = MEMWB;
      end
      MEMWB:    w_next = FETCH;
      MEMWRITE: begin
        if (MemReady) w_next = FETCH;
      end
      EXECUTER: w_next = ALUWB;
      EXECUTEI: w_next = ALUWB;
      ALUWB:    w_next = FETCH;
      BRANCH:   w_next = FETCH;
      default:  w_next = FETCH;
    endcase
  end

  logic       w_pcw;
  logic       w_irw;
  logic       w_mw;
  logic       w_wb;
  logic       w_adr;
  logic       w_srca;
  logic [1:0] w_srcb;
  logic [1:0] w_res;

  // Moore outputs per state
  always_comb begin
    w_pcw  = 1'b0;
    w_irw  = 1'b0;
    w_mw   = 1'b0;
    w_wb   = 1'b0;
    w_adr  = 1'b0;
    w_srca = 1'b0;
    w_srcb = 2'b00;
    w_res  = 2'b00;
    unique case (r_state)
      FETCH: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_res  = 2'b10;
        w_irw  = MemReady;
        w_pcw  = MemReady;
      end
      DECODE: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_res  = 2'b10;
      end
      MEMADR: w_srcb = 2'b01;
      MEMREAD: w_adr = 1'b1;
      MEMWB: begin
        w_res = 2'b01;
        w_wb  = 1'b1;
      end
      MEMWRITE: begin
        w_adr = 1'b1;
        w_mw  = 1'b1;
      end
      EXECUTER: w_srcb = 2'b00;
      EXECUTEI: w_srcb = 2'b01;
      ALUWB: begin
        w_res = 2'b00;
        w_wb  = w_alu_wb;
      end
      BRANCH: begin
        w_srcb = 2'b01;
        w_res  = 2'b10;
        w_pcw  = 1'b1;
      end
      default: ;
    endcase
  end

  logic w_rd_pc;
  assign w_rd_pc = (w_rd == 4'b1111);

  // ALU operation, only meaningful while executing
  always_comb begin
    ALUControl = 3'b000;
    if (w_exec) begin
      unique case (1'b1)
        w_is_sub, w_is_cmp: ALUControl = 3'b001;
        w_is_and: ALUControl = 3'b010;
        w_is_orr: ALUControl = 3'b011;
        default:  ALUControl = 3'b000;
      endcase
    end
  end

  assign PCWrite  = reset
                  & (w_pcw | (w_wb & w_rd_pc));
  assign IRWrite  = reset & w_irw;
  assign RegWrite = reset & w_wb & ~w_rd_pc;
  assign MemWrite = reset & w_mw;

  assign AdrSrc    = w_adr;
  assign ALUSrcA   = w_srca;
  assign ALUSrcB   = w_srcb;
  assign ResultSrc = w_res;

  assign ImmSrc    = w_op;
  assign RegSrc[0] = (w_op == 2'b10);
  assign RegSrc[1] = (w_op == 2'b01) & ~w_funct[0];

  assign Flags = r_flags;
  assign State = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl.
// Random and directed instructions against a path-level reference model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;
  logic        MemReady = 1'b0;
  logic        PCWrite, IRWrite, RegWrite, MemWrite;
  logic        AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  Flags, State;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Instr(Instr),
    .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .Flags(Flags),
    .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] S_FETCH = 4'd0;
  localparam logic [3:0] S_DEC   = 4'd1;
  localparam logic [3:0] S_MADR  = 4'd2;
  localparam logic [3:0] S_MRD   = 4'd3;
  localparam logic [3:0] S_MWB   = 4'd4;
  localparam logic [3:0] S_MWR   = 4'd5;
  localparam logic [3:0] S_EXR   = 4'd6;
  localparam logic [3:0] S_EXI   = 4'd7;
  localparam logic [3:0] S_AWB   = 4'd8;
  localparam logic [3:0] S_BR    = 4'd9;

  int errors = 0;
  int checks = 0;
  logic [3:0] m_flags = 4'b0000;

  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n, z, cc, v;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cc && !z;
      4'h9: return !cc || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 CMP, 5 NOP
  function automatic int alu_kind(logic [3:0] cmd);
    case (cmd)
      4'b0100: return 0;
      4'b0010: return 1;
      4'b0000: return 2;
      4'b1100: return 3;
      4'b1010: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic logic [16:0] exp_ctl(logic [3:0] st,
                                          logic [31:0] i, bit mr);
    logic pcw, irw, rw, mw, adr, sa;
    logic [1:0] sb, rs, imm, rsrc;
    logic [2:0] alu;
    bit wb;
    int k;
    k = alu_kind(i[24:21]);
    {pcw, irw, rw, mw, adr, sa} = '0;
    sb = 0; rs = 0; alu = 0; wb = 0;
    imm = i[27:26];
    rsrc = {(i[27:26] == 2'b01 && !i[20]),
            (i[27:26] == 2'b10)};
    case (st)
      S_FETCH: begin
        sa = 1; sb = 2; rs = 2; irw = mr; pcw = mr;
      end
      S_DEC:  begin sa = 1; sb = 2; rs = 2; end
      S_MADR: sb = 1;
      S_MRD:  adr = 1;
      S_MWB:  begin rs = 1; wb = 1; end
      S_MWR:  begin adr = 1; mw = 1; end
      S_EXR, S_EXI: begin
        sb = (st == S_EXI) ? 2'd1 : 2'd0;
        case (k)
          1, 4: alu = 3'b001;
          2: alu = 3'b010;
          3: alu = 3'b011;
          default: alu = 3'b000;
        endcase
      end
      S_AWB: wb = (k < 4);
      S_BR:  begin sb = 1; rs = 2; pcw = 1; end
      default: ;
    endcase
    if (wb) begin
      if (i[15:12] == 4'hF) pcw = 1;
      else rw = 1;
    end
    return {pcw, irw, rw, mw, adr, sa, sb, rs, alu, imm, rsrc};
  endfunction

  // run one instruction from FETCH; wf/wm are memory wait cycles
  task automatic run_instr(input logic [31:0] i,
                           input logic [3:0] af,
                           input int wf, input int wm);
    logic [3:0] sq[$];
    bit mq[$];
    logic [16:0] act, exv;
    bit ok;
    int k;
    ok = cond_ok(i[31:28], m_flags);
    k = alu_kind(i[24:21]);
    for (int n = 0; n < wf; n++) begin sq.push_back(S_FETCH); mq.push_back(0); end
    sq.push_back(S_FETCH); mq.push_back(1);
    sq.push_back(S_DEC); mq.push_back(1'($urandom));
    if (ok) begin
      case (i[27:26])
        2'b01: begin
          sq.push_back(S_MADR); mq.push_back(1'($urandom));
          for (int n = 0; n < wm; n++) begin
            sq.push_back(i[20] ? S_MRD : S_MWR); mq.push_back(0);
          end
          sq.push_back(i[20] ? S_MRD : S_MWR); mq.push_back(1);
          if (i[20]) begin sq.push_back(S_MWB); mq.push_back(1'($urandom)); end
        end
        2'b00: begin
          sq.push_back(i[25] ? S_EXI : S_EXR); mq.push_back(1'($urandom));
          sq.push_back(S_AWB); mq.push_back(1'($urandom));
        end
        2'b10: begin sq.push_back(S_BR); mq.push_back(1'($urandom)); end
        default: ;
      endcase
    end
    Instr = i[31:12];
    ALUFlags = af;
    for (int c = 0; c < sq.size(); c++) begin
      MemReady = mq[c];
      @(negedge clk);
      checks++;
      if (State !== sq[c]) begin
        errors++;
        $display("FAIL state instr=%h cyc=%0d got=%0d exp=%0d",
                 i, c, State, sq[c]);
      end
      act = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
             ImmSrc, RegSrc};
      exv = exp_ctl(sq[c], i, mq[c]);
      checks++;
      if (act !== exv) begin
        errors++;
        $display("FAIL ctl instr=%h cyc=%0d st=%0d got=%h exp=%h",
                 i, c, sq[c], act, exv);
      end
      @(posedge clk); #1;
    end
    if (ok && i[27:26] == 2'b00) begin
      if (k < 2 && i[20]) m_flags = af;
      else if (k == 4) m_flags = af;
      else if (k < 4 && i[20]) m_flags[3:2] = af[3:2];
    end
    checks++;
    if (Flags !== m_flags) begin
      errors++;
      $display("FAIL flags instr=%h got=%b exp=%b", i, Flags, m_flags);
    end
  endtask

  task automatic test_reset();
    reset = 0; MemReady = 1; Instr = 20'hE2821;
    #2;
    checks++;
    if (State !== S_FETCH || Flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state got=%0d/%b exp=0/0000", State, Flags);
    end
    checks++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_enables got=%b exp=0000",
               {PCWrite, IRWrite, RegWrite, MemWrite});
    end
    @(posedge clk); #1;
    reset = 1;
  endtask

  task automatic test_dp();
    run_instr(32'hE2821005, 4'b1111, 1, 0);
    run_instr(32'hE280F000, 4'b0000, 0, 0);
  endtask

  task automatic test_ldr();
    run_instr(32'hE5910004, 4'b0000, 0, 3);
  endtask

  task automatic test_cmp();
    run_instr(32'hE1500000, 4'b0110, 0, 0);
    checks++;
    if (Flags !== 4'b0110) begin
      errors++;
      $display("FAIL cmp_flags got=%b exp=0110", Flags);
    end
  endtask

  task automatic test_branch();
    run_instr(32'hE1500000, 4'b0100, 0, 0);
    run_instr(32'h0A000002, 4'b0000, 0, 0);
    run_instr(32'hE1500000, 4'b0000, 0, 0);
    run_instr(32'h0A000002, 4'b0000, 2, 0);
  endtask

  task automatic test_str();
    run_instr(32'hE5843000, 4'b0000, 0, 0);
    run_instr(32'hE5843000, 4'b0000, 0, 2);
  endtask

  task automatic test_reset_abort();
    run_instr(32'hE1500000, 4'b1011, 0, 0);
    Instr = 20'hE5843; MemReady = 1;
    repeat (3) begin @(posedge clk); #1; end
    MemReady = 0;
    #2;
    checks++;
    if (State !== S_MWR || MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got=%0d/%b exp=5/1", State, MemWrite);
    end
    reset = 0;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || State !== S_FETCH || Flags !== 4'b0000) begin
      errors++;
      $display("FAIL abort_now got=%b/%0d/%b exp=0/0/0000",
               MemWrite, State, Flags);
    end
    MemReady = 1;
    #1;
    checks++;
    if (IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
      errors++;
      $display("FAIL abort_irw got=%b%b exp=00", IRWrite, PCWrite);
    end
    @(posedge clk); #1;
    reset = 1; MemReady = 0; m_flags = 4'b0000;
    @(negedge clk);
    checks++;
    if (IRWrite !== 1'b0 || State !== S_FETCH) begin
      errors++;
      $display("FAIL fetch_wait got=%b/%0d exp=0/0", IRWrite, State);
    end
    @(posedge clk); #1;
    MemReady = 1;
    @(negedge clk);
    checks++;
    if (IRWrite !== 1'b1) begin
      errors++;
      $display("FAIL fetch_ready got=%b exp=1", IRWrite);
    end
    @(posedge clk); #1;
    Instr = 20'hF2821;
    @(posedge clk); #1;
    checks++;
    if (State !== S_FETCH) begin
      errors++;
      $display("FAIL nv_skip got=%0d exp=0", State);
    end
  endtask

  task automatic test_latency();
    logic [31:0] ins[5];
    int lat[5];
    int n;
    ins = '{32'hE2821005, 32'hE5910004, 32'hE5843000,
            32'hEA000002, 32'hF2821005};
    lat = '{4, 5, 4, 3, 2};
    for (int t = 0; t < 5; t++) begin
      Instr = ins[t][31:12];
      MemReady = 1;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (State !== S_FETCH && n < 10);
      checks++;
      if (n !== lat[t]) begin
        errors++;
        $display("FAIL latency instr=%h got=%0d exp=%0d", ins[t], n, lat[t]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] i;
    logic [3:0] cmds[6];
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b0111};
    for (int r = 0; r < 60; r++) begin
      i = $urandom;
      if ($urandom_range(3) != 0) i[31:28] = 4'hE;
      if (i[27:26] == 2'b00 && $urandom_range(3) != 0)
        i[24:21] = cmds[$urandom_range(5)];
      if ($urandom_range(5) == 0) i[15:12] = 4'hF;
      run_instr(i, 4'($urandom), $urandom_range(2), $urandom_range(2));
    end
  endtask

  initial begin
    test_reset();
    test_dp();
    test_ldr();
    test_cmp();
    test_branch();
    test_str();
    test_reset_abort();
    test_latency();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
